// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame constants.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 6;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin, plus a delay flop for falling-edge detect.
// All three flops reset to the idle line level so leaving reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_sync,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rx;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_sync = sync_q;
    assign fall    = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start/data/(parity)/stop, LSB-first, one-cycle result pulses.
// Optional parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);

    logic                 rx_sync;
    logic                 fall;
    logic                 at_last;
    logic                 parity_pending;

    uart_rx_state_t       state_q, state_d;
    logic [BW-1:0]        baud_cnt_q, baud_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_sync (rx_sync),
        .fall    (fall)
    );

    assign at_last = (baud_cnt_q == BAUD_LAST);

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Next-state logic; counters restart on every state entry and every sample.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (baud_cnt_q == BAUD_HALF) begin
                    baud_cnt_d = '0;
                    state_d    = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (at_last) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_sync, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_last) begin
                    baud_cnt_d = '0;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (at_last) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                state_d    = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;

    // Parity verdict is latched at the parity sample and consumed at the stop sample.
    always_comb begin
        par_bad_d = par_bad_q;
        if (state_q == IDLE)
            par_bad_d = 1'b0;
        else if (state_q == PARITY && at_last)
            par_bad_d = ((^shift_q) ^ (PARITY_ODD != 0)) != rx_sync;
    end

    always_ff @(posedge clk) begin
        if (reset) par_bad_q <= 1'b0;
        else       par_bad_q <= par_bad_d;
    end

    assign parity_pending = par_bad_q;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
    assign parity_pending    = 1'b0;
`endif

    // Output logic: result pulses are computed at the stop sample and registered.
    always_comb begin
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        data_d       = data_q;
        if (state_q == STOP && at_last) begin
            frame_err_d  = ~rx_sync;
            parity_err_d = parity_pending;
            if (rx_sync && !parity_pending) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected result pulses (flags, data, cycle) are queued as
// frames are driven and compared when the receiver pulses an output.
module tb_uart_rx;

    localparam int CPB = 6;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    // Start-bit drive cycle to result pulse: 2 sync stages, half bit, full bits, register stage.
    localparam int LAT = 2 + CPB / 2 + (DB + 1 + PB) * CPB + 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          rx    = 1'b1;
    logic [DB-1:0] data_out;
    logic          valid_out;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] flags;   // {valid, frame_err, parity_err}
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks    = 0;
    int         failures  = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Any result pulse must match the oldest queued expectation exactly.
    always @(negedge clk) begin
        if (!reset && (valid_out || frame_err || parity_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {29'd0, valid_out, frame_err, parity_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_flags", {29'd0, valid_out, frame_err, parity_err}, {29'd0, mon_e.flags});
                check("pulse_data", {24'd0, data_out}, {24'd0, mon_e.data});
                check("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        hold(CPB);
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop,
                        input logic [2:0] flags, input logic [7:0] exp_data);
        exp_t e;
        e.flags = flags;
        e.data  = exp_data;
        e.cyc   = cyc + LAT;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PB != 0) drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic send_good(input logic [7:0] d);
        send(d, ^d, 1'b1, 3'b100, d);
        last_good = d;
    endtask

    initial begin
        int c;

        // Reset state
        hold(3);
        check("reset_data", {24'd0, data_out}, 32'd0);
        check("reset_valid", {31'd0, valid_out}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        hold(5);

        // Nominal frame
        send_good(8'hA5);
        hold(10);

        // Start-bit glitch: two low cycles, rejected at the start sample
        c  = cyc;
        rx = 1'b0;
        hold(2);
        rx = 1'b1;
        hold(1);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        hold(3);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_elapsed", cyc - c, 32'd6);
        hold(10);

        // Framing error keeps previous data
        send(8'h3C, ^8'h3C, 1'b0, 3'b010, last_good);
        rx = 1'b1;
        hold(10);

        // Break: line held low yields exactly one frame error and no restart
        send(8'h00, 1'b0, 1'b0, 3'b010, last_good);
        hold(40);
        rx = 1'b1;
        hold(20);
        check("break_busy", {31'd0, busy}, 32'd0);

        // Back-to-back frames, no idle gap
        send_good(8'h00);
        send_good(8'hFF);
        hold(10);

        // Reset during data bit 4
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        hold(3);
        rx    = 1'b1;
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
        check("midreset_data", {24'd0, data_out}, 32'd0);
        check("midreset_valid", {31'd0, valid_out}, 32'd0);
        check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        check("midreset_parity_err", {31'd0, parity_err}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        last_good = 8'h00;
        hold(20);
        send_good(8'h5A);
        hold(10);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        send(8'h07, 1'b0, 1'b1, 3'b001, last_good);
        hold(10);
        send_good(8'h07);
        hold(10);
        // Parity and framing errors together
        send(8'h07, 1'b0, 1'b0, 3'b011, last_good);
        rx = 1'b1;
        hold(10);
`endif

        for (int i = 0; i < 200 && sb.size() != 0; i++) hold(1);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of the team's UART transmitter. It synchronises the asynchronous serial line `rx`, detects and validates the start bit, and samples each data bit at mid-bit using a baud counter. Data is shifted in LSB first, the stop bit is checked, and each result is presented as a one-cycle `valid_out` pulse with parallel data, or as an error pulse. Frame format is 1 start bit, `DATA_BITS` data bits, an optional parity bit and 1 stop bit. Line idle level is high.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 6: clk cycles per serial bit; must be at least 4.
- `DATA_BITS`, default 8: data bits per frame; legal range 5..8.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Used only when `UART_RX_PARITY_EN` is defined.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle level is 1.
- `data_out`  out  DATA_BITS  last correctly received word; held until the next valid frame.
- `valid_out`  out  1  one-cycle pulse; `data_out` is updated in the same cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled as 0.
- `parity_err`  out  1  one-cycle pulse when the parity bit mismatches; tied to 0 without the macro.
- `busy`  out  1  high in every FSM state other than IDLE.

## Operation
- **Synchroniser:** two flops whose reset value is 1, giving `rx_sync`. A third flop gives `rx_prev`. A falling edge is defined as `rx_prev==1 && rx_sync==0`.
- **Counters:**
  - `baud_cnt` is $clog2(CLKS_PER_BIT) bits wide.
  - `bit_cnt` is 4 bits wide.
  - Both are cleared on every state entry and on every sample.
  - HALF = CLKS_PER_BIT/2, using integer division.
- **FSM states and transitions:**
  - IDLE: on a falling edge, go to START with `baud_cnt` set to 0.
  - START: sample when `baud_cnt==HALF-1`.
    - If `rx_sync==0`, go to DATA.
    - If `rx_sync==1`, the edge was a glitch; return to IDLE with no output.
  - DATA: sample when `baud_cnt==CLKS_PER_BIT-1`.
    - Shift in at the MSB end and shift right, so that bit 0 is the bit received first.
    - Increment `bit_cnt`.
    - After DATA_BITS samples, go to PARITY if the macro is defined, otherwise to STOP.
  - PARITY: sample when `baud_cnt==CLKS_PER_BIT-1`, then go to STOP.
  - STOP: sample when `baud_cnt==CLKS_PER_BIT-1`.
    - If 1, and no parity error is pending, the frame is good. Update `data_out` from the shift register and pulse `valid_out`.
    - If 0, pulse `frame_err` and leave `data_out` unchanged.
    - If a parity error is pending, pulse `parity_err` and leave `data_out` unchanged.
    - Go to IDLE in all cases.
- **Boundary conditions:**
  - When `frame_err` and `parity_err` both apply, both pulse in the same cycle.
  - A line held low (break) produces a single `frame_err`. No new frame starts until the line has gone high and then low again, because IDLE requires an edge.
  - Back-to-back frames are accepted: IDLE is re-entered half a bit before the stop bit ends.
  - Reset mid-frame: FSM goes to IDLE, counters clear, synchroniser flops go to 1.
- **Reset values:**
  - `data_out` = 0
  - `valid_out` = 0
  - `frame_err` = 0
  - `parity_err` = 0
  - `busy` = 0

## Timing
- `rx_sync` lags the `rx` pin by 2 cycles.
- Let E be the first cycle with `rx_sync==0` following a high level.
  - The start bit is sampled at E+HALF.
  - Data bit k, for k = 0..DATA_BITS-1, is sampled at E+HALF+(k+1)·CLKS_PER_BIT.
  - The stop bit is sampled at E+HALF+(DATA_BITS+1+P)·CLKS_PER_BIT, where P=1 with the macro and P=0 without.
  - `valid_out`, `frame_err` and `parity_err` are registered and assert in the cycle after the stop sample.
- With the defaults (6 clocks per bit, 8 data bits, no parity), the stop bit is sampled at E+57 and `valid_out` asserts at E+58.
- `busy` rises in cycle E+1 and falls in the cycle after the stop sample.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:**
  - PARITY state is included.
  - Expected parity is the XOR of the data bits XOR `PARITY_ODD`.
  - `parity_err` is live.
- **Undefined:**
  - PARITY state is absent and the frame is 1 + DATA_BITS + 1 bits long.
  - `parity_err` is constant 0.
  - The port list is identical in both builds.

## Structure
- Shared package `uart_pkg` contains:
  - `uart_rx_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - Default constants `UART_CLKS_PER_BIT` = 6 and `UART_DATA_BITS` = 8.
- One sub-module, `uart_rx_sync`: the 2-flop synchroniser plus edge-detect flop, with outputs `rx_sync` and `fall`.

## Test plan
- **Nominal frame:** send 0xA5 with defaults → `valid_out` pulses once at E+58 with `data_out` = 0xA5; `frame_err` stays 0.
- **Start-bit glitch:** drive `rx` low for 2 cycles, then high → no pulses on any output; `busy` returns to 0 by E+4.
- **Framing error:** send 0x3C with a stop bit of 0 → `frame_err` pulses at E+58; `valid_out` stays 0; `data_out` keeps its previous value.
- **Back-to-back frames:** send 0x00 then 0xFF with no idle gap → two `valid_out` pulses 60 cycles apart, with data 0x00 then 0xFF.
- **Reset mid-frame:** assert `reset` during data bit 4 → all outputs are 0 the next cycle; the next frame, 0x5A, is received correctly.
- **Parity (with `UART_RX_PARITY_EN`, even parity):** send 0x07 with a parity bit of 0 → `parity_err` pulses at E+64 and `valid_out` stays 0. Resend with a parity bit of 1 → `valid_out` pulses with `data_out` = 0x07.
